// File: rtl/integer_division_core.sv
// integer_division_core: per-frame AWB gain calculator.
// On each falling edge of vsync, computes gain_X = ({mean_G[31:16], 8'd0}) / mean_X[31:16]
// for X in R, G, B using one shared restoring radix-2 divider (24 cycles per channel).
// All three gains update together 74 clocks after the detection edge.
// Optional build macro GAIN_CLIP_EN: clamps each gain to 1023 (about 4.0 in Q8).
module integer_division_core #(
  parameter int unsigned         DIV_W    = 24,
  parameter int unsigned         DVS_W    = 16,
  parameter logic [DIV_W-1:0]    GAIN_ONE = 24'd256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vsync,
  input  logic [31:0]      mean_R,
  input  logic [31:0]      mean_G,
  input  logic [31:0]      mean_B,
  output logic [DIV_W-1:0] gain_R,
  output logic [DIV_W-1:0] gain_G,
  output logic [DIV_W-1:0] gain_B
);

  localparam int unsigned REM_W = DVS_W + 1;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);
  localparam logic [DIV_W-1:0] CLIP_MAX = DIV_W'(1023);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV_R,
    ST_DIV_G,
    ST_DIV_B,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               vsync_q, vsync_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVS_W-1:0]   dvs_r_q, dvs_r_d;
  logic [DVS_W-1:0]   dvs_g_q, dvs_g_d;
  logic [DVS_W-1:0]   dvs_b_q, dvs_b_d;
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [DIV_W-1:0]   quo_q, quo_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]   res_r_q, res_r_d;
  logic [DIV_W-1:0]   res_g_q, res_g_d;
  logic [DIV_W-1:0]   gain_r_q, gain_r_d;
  logic [DIV_W-1:0]   gain_g_q, gain_g_d;
  logic [DIV_W-1:0]   gain_b_q, gain_b_d;

  logic [DVS_W-1:0]   dvs_cur;
  logic [REM_W-1:0]   rem_sh;
  logic [REM_W-1:0]   rem_nx;
  logic [DIV_W-1:0]   quo_nx;
  logic               q_bit;

  // Low halves of the statistics are intentionally ignored.
  logic unused_mean_lo;
  assign unused_mean_lo = ^{mean_R[15:0], mean_G[15:0], mean_B[15:0]};

  // Final gain shaping applied when results are published.
  function automatic logic [DIV_W-1:0] shape_gain(input logic [DIV_W-1:0] q);
`ifdef GAIN_CLIP_EN
    return (q > CLIP_MAX) ? CLIP_MAX : q;
`else
    return q;
`endif
  endfunction

  // One restoring-division step; a zero divisor naturally yields all-ones quotient bits.
  always_comb begin
    dvs_cur = dvs_r_q;
    if (state_q == ST_DIV_G) dvs_cur = dvs_g_q;
    if (state_q == ST_DIV_B) dvs_cur = dvs_b_q;
    rem_sh = REM_W'({rem_q, quo_q[DIV_W-1]});
    q_bit  = (rem_sh >= {1'b0, dvs_cur});
    rem_nx = q_bit ? (rem_sh - {1'b0, dvs_cur}) : rem_sh;
    quo_nx = {quo_q[DIV_W-2:0], q_bit};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    vsync_d  = vsync;
    cnt_d    = cnt_q;
    dvs_r_d  = dvs_r_q;
    dvs_g_d  = dvs_g_q;
    dvs_b_d  = dvs_b_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    res_r_d  = res_r_q;
    res_g_d  = res_g_q;
    gain_r_d = gain_r_q;
    gain_g_d = gain_g_q;
    gain_b_d = gain_b_q;

    case (state_q)
      ST_IDLE: begin
        if (vsync_q && !vsync) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        dvs_r_d = mean_R[31:16];
        dvs_g_d = mean_G[31:16];
        dvs_b_d = mean_B[31:16];
        dvd_d   = {mean_G[31:16], 8'd0};
        quo_d   = {mean_G[31:16], 8'd0};
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ST_DIV_R;
      end
      ST_DIV_R, ST_DIV_G, ST_DIV_B: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          rem_d = '0;
          quo_d = dvd_q;
          if (state_q == ST_DIV_R) begin
            res_r_d = quo_nx;
            state_d = ST_DIV_G;
          end else if (state_q == ST_DIV_G) begin
            res_g_d = quo_nx;
            state_d = ST_DIV_B;
          end else begin
            // Blue result stays in the working register until publication.
            quo_d   = quo_nx;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        gain_r_d = shape_gain(res_r_q);
        gain_g_d = shape_gain(res_g_q);
        gain_b_d = shape_gain(quo_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      vsync_q  <= 1'b0;
      cnt_q    <= '0;
      dvs_r_q  <= '0;
      dvs_g_q  <= '0;
      dvs_b_q  <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      res_r_q  <= '0;
      res_g_q  <= '0;
      gain_r_q <= GAIN_ONE;
      gain_g_q <= GAIN_ONE;
      gain_b_q <= GAIN_ONE;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync_d;
      cnt_q    <= cnt_d;
      dvs_r_q  <= dvs_r_d;
      dvs_g_q  <= dvs_g_d;
      dvs_b_q  <= dvs_b_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      res_r_q  <= res_r_d;
      res_g_q  <= res_g_d;
      gain_r_q <= gain_r_d;
      gain_g_q <= gain_g_d;
      gain_b_q <= gain_b_d;
    end
  end

  assign gain_R = gain_r_q;
  assign gain_G = gain_g_q;
  assign gain_B = gain_b_q;

endmodule

// File: tb/tb_integer_division_core.sv
// Testbench for integer_division_core: directed frames from the plan plus randomized
// frames, checked against an arithmetic reference of the gain formula.
module tb_integer_division_core;

  logic        clk;
  logic        reset_n;
  logic        vsync;
  logic [31:0] mean_R;
  logic [31:0] mean_G;
  logic [31:0] mean_B;
  logic [23:0] gain_R;
  logic [23:0] gain_G;
  logic [23:0] gain_B;

  int n_checks;
  int n_errors;

  logic [23:0] exp_r;
  logic [23:0] exp_g;
  logic [23:0] exp_b;

  integer_division_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .mean_R  (mean_R),
    .mean_G  (mean_G),
    .mean_B  (mean_B),
    .gain_R  (gain_R),
    .gain_G  (gain_G),
    .gain_B  (gain_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%06h) expected %0d (0x%06h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference gain: floor((g * 256) / d), saturating divide-by-zero, optional clamp.
  function automatic logic [23:0] ref_gain(input logic [15:0] g, input logic [15:0] d);
    longint q;
    if (d == 16'd0) q = 64'hFF_FFFF;
    else q = (longint'(g) * 256) / longint'(d);
`ifdef GAIN_CLIP_EN
    if (q > 1023) q = 1023;
`endif
    return 24'(q);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "_R"}, gain_R, exp_r);
    check_eq({tag, "_G"}, gain_G, exp_g);
    check_eq({tag, "_B"}, gain_B, exp_b);
  endtask

  // One vsync frame; detection edge k is the first edge after vsync drops.
  task automatic run_frame(input logic [31:0] mr, input logic [31:0] mg, input logic [31:0] mb,
                           input bit extra_edge, input bit mid_reset);
    logic [23:0] nr, ng, nb;
    nr = ref_gain(mg[31:16], mr[31:16]);
    ng = ref_gain(mg[31:16], mg[31:16]);
    nb = ref_gain(mg[31:16], mb[31:16]);
    @(posedge clk); #1;
    mean_R = mr; mean_G = mg; mean_B = mb;
    vsync  = 1'b1;
    @(posedge clk); #1;
    vsync  = 1'b0;
    @(posedge clk); #1;                 // after edge k
    @(posedge clk); #1;                 // after edge k+1: operands latched
    mean_R = $urandom; mean_G = $urandom; mean_B = $urandom;
    for (int e = 2; e <= 73; e++) begin
      @(posedge clk); #1;
      if (extra_edge && e == 28) vsync = 1'b1;
      if (extra_edge && e == 29) vsync = 1'b0;
      if (extra_edge && e == 50) begin
        mean_R = $urandom; mean_G = $urandom; mean_B = $urandom;
      end
      if (mid_reset && e == 40) begin
        reset_n = 1'b0;
        #1;
        exp_r = 24'd256; exp_g = 24'd256; exp_b = 24'd256;
        check_all("mid_reset");
        #2;
        reset_n = 1'b1;
      end
    end
    check_all("pre_update");
    @(posedge clk); #1;                 // after edge k+74
    if (!mid_reset) begin
      exp_r = nr; exp_g = ng; exp_b = nb;
    end
    check_all(mid_reset ? "no_update" : "update");
    @(posedge clk); #1;
    check_all("hold");
  endtask

  function automatic logic [15:0] rand_div();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 16'd0;
    if (sel == 1) return 16'd1;
    if (sel == 2) return 16'($urandom_range(1, 15));
    return 16'($urandom_range(0, 65535));
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_r = 24'd256; exp_g = 24'd256; exp_b = 24'd256;
    reset_n = 1'b0;
    vsync   = 1'b0;
    mean_R  = '0; mean_G = '0; mean_B = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Idle with vsync low: no computation ever starts.
    for (int i = 0; i < 5; i++) begin
      mean_R = $urandom; mean_G = $urandom; mean_B = $urandom;
      repeat (20) @(posedge clk);
      #1;
      check_all("idle");
    end

    run_frame(32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 1'b0, 1'b0);
    run_frame(32'h0003_0000, 32'h0064_0000, 32'h00C8_0000, 1'b0, 1'b0);
    run_frame(32'h0002_1234, 32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0);
    run_frame(32'h0005_AAAA, 32'h0123_5555, 32'h0007_0001, 1'b1, 1'b0);
    run_frame(32'h0010_0000, 32'h0020_0000, 32'h0040_0000, 1'b0, 1'b1);
    run_frame(32'h0010_0000, 32'h0020_0000, 32'h0040_0000, 1'b0, 1'b0);
    run_frame(32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 1'b0);

    for (int f = 0; f < 20; f++) begin
      logic [31:0] mr, mg, mb;
      mr = {rand_div(), 16'($urandom)};
      mg = {rand_div(), 16'($urandom)};
      mb = {rand_div(), 16'($urandom)};
      run_frame(mr, mg, mb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
